// File: rtl/key_frame_sender.sv
// Frames key_down as SYNC, length, data bytes (LSB byte first) toward the uart.
// Define KEY_CHECKSUM_EN to append an XOR checksum byte.
module key_frame_sender #(
  parameter int unsigned KEY_COUNT = 40,
  parameter int unsigned PERIOD    = 2400000,
  parameter int unsigned TIMEOUT   = 65535,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_COUNT-1:0] key_down,
  input  logic                 force_req,
  output logic                 uart_send,
  output logic [7:0]           uart_send_data,
  input  logic                 uart_send_done,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          frame_cnt,
  output logic [3:0]           sta
);

  localparam int unsigned NBYTES = (KEY_COUNT + 7) / 8;
  localparam int unsigned NPAD   = NBYTES * 8;
`ifdef KEY_CHECKSUM_EN
  localparam int unsigned NFRAME = NBYTES + 3;
`else
  localparam int unsigned NFRAME = NBYTES + 2;
`endif
  localparam logic [7:0]  LAST_IDX = 8'(NFRAME - 1);
  localparam logic [7:0]  LEN_BYTE = 8'(NBYTES);
  localparam bit          PER_EN   = (PERIOD != 0);
  localparam logic [31:0] PER_M1   =
    (PERIOD == 0) ? 32'd0 : 32'(PERIOD - 1);
  localparam logic [31:0] TMO_M1   =
    (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NPAD-1:0]      snap_q, snap_d;
  logic [KEY_COUNT-1:0] last_q, last_d;
  logic                 pend_q, pend_d;
  logic [31:0]          pcnt_q, pcnt_d;
  logic [31:0]          tcnt_q, tcnt_d;
  logic [7:0]           idx_q, idx_d;
  logic                 send_q, send_d;
  logic [7:0]           data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [15:0]          fcnt_q, fcnt_d;

  logic [NPAD-1:0] key_pad;
  logic [7:0]      cur_byte;
  logic            trig;
  logic            tmo;
  logic            last_byte;

  assign key_pad   = NPAD'(key_down);
  assign tmo       = (tcnt_q == TMO_M1);
  assign last_byte = (idx_q == LAST_IDX);
  assign trig      = (key_down != last_q) | force_req | pend_q |
                     (PER_EN && (pcnt_q == PER_M1));

`ifdef KEY_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = LEN_BYTE;
    for (int b = 0; b < int'(NBYTES); b++) begin
      csum = csum ^ snap_q[b*8 +: 8];
    end
  end
`endif

  always_comb begin
    cur_byte = SYNC_BYTE;
    if (idx_q == 8'd1) cur_byte = LEN_BYTE;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (idx_q == 8'(b + 2)) cur_byte = snap_q[b*8 +: 8];
    end
`ifdef KEY_CHECKSUM_EN
    if (idx_q == 8'(NBYTES + 2)) cur_byte = csum;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      last_q  <= '0;
      pend_q  <= 1'b0;
      pcnt_q  <= 32'd0;
      tcnt_q  <= 32'd0;
      idx_q   <= 8'd0;
      send_q  <= 1'b0;
      data_q  <= 8'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      send_q  <= send_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (trig) state_d = S_LOAD;
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (uart_send_done) begin
          state_d = last_byte ? S_DONE : S_LOAD;
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    snap_d = snap_q;
    last_d = last_q;
    pend_d = pend_q;
    pcnt_d = 32'd0;
    tcnt_d = tcnt_q;
    idx_d  = idx_q;
    send_d = 1'b0;
    data_d = data_q;
    busy_d = busy_q;
    err_d  = err_q;
    fcnt_d = fcnt_q;
    // snapshot stays frozen; later changes are replayed after DONE
    if (state_q != S_IDLE) begin
      if (force_req || (key_pad != snap_q)) pend_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        pcnt_d = pcnt_q + 32'd1;
        if (trig) begin
          snap_d = key_pad;
          last_d = key_down;
          pcnt_d = 32'd0;
          pend_d = 1'b0;
          idx_d  = 8'd0;
          busy_d = 1'b1;
        end
      end
      S_LOAD: begin
        send_d = 1'b1;
        data_d = cur_byte;
        tcnt_d = 32'd0;
      end
      S_WAIT: begin
        if (uart_send_done) begin
          if (!last_byte) idx_d = idx_q + 8'd1;
        end else if (tmo) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      S_DONE: begin
        fcnt_d = fcnt_q + 16'd1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    uart_send      = send_q;
    uart_send_data = data_q;
    busy           = busy_q;
    err            = err_q;
    frame_cnt      = fcnt_q;
    sta            = {2'b00, state_q};
  end

endmodule

// File: tb/tb_key_frame_sender.sv
// Directed bench for key_frame_sender with a byte-capturing uart model.
// Build with or without KEY_CHECKSUM_EN; expected frames follow the macro.
module tb_key_frame_sender;

  localparam int KC = 12;
`ifdef KEY_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [KC-1:0] key_down = '0;
  logic          force_req = 1'b0;
  logic          uart_send;
  logic [7:0]    uart_send_data;
  logic          uart_send_done = 1'b0;
  logic          busy;
  logic          err;
  logic [15:0]   frame_cnt;
  logic [3:0]    sta;

  int n_run = 0;
  int n_fail = 0;
  int resp_delay = -1;
  int pend = -1;
  int exp_fc = 0;
  logic [7:0] cap_q[$];

  key_frame_sender #(
    .KEY_COUNT(KC),
    .PERIOD(100),
    .TIMEOUT(50),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_down(key_down),
    .force_req(force_req),
    .uart_send(uart_send),
    .uart_send_data(uart_send_data),
    .uart_send_done(uart_send_done),
    .busy(busy),
    .err(err),
    .frame_cnt(frame_cnt),
    .sta(sta)
  );

  always #5 clk = ~clk;

  // uart model: capture each strobed byte, answer done resp_delay cycles later
  initial begin
    forever begin
      @(negedge clk);
      uart_send_done = 1'b0;
      if (!rst) begin
        pend = -1;
      end else if (uart_send === 1'b1) begin
        cap_q.push_back(uart_send_data);
        pend = resp_delay;
      end
      if (pend == 0) begin
        uart_send_done = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: sim time expired, %0d failed so far", n_fail);
    $fatal(1);
  end

  task automatic wait_sta(input logic [3:0] v, input int bound,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sta === v) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_force();
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({uart_send, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {uart_send, busy, err});
    end
    n_run++;
    if (frame_cnt !== 16'd0 || sta !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got fc=%h sta=%h want 0 0", frame_cnt, sta);
    end
    rst = 1'b1;
    @(negedge clk);
    n_run++;
    if (sta !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got sta=%h busy=%b want 0 0", sta, busy);
    end
  endtask

  task automatic test_frame();
    logic [7:0] ex [5] = '{8'hA5, 8'h02, 8'h53, 8'h0A, 8'h5B};
    bit ok;
    cap_q.delete();
    resp_delay = 10;
    key_down = 12'hA53;
    @(negedge clk);
    n_run++;
    if (sta !== 4'd1 || uart_send !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_load: got sta=%h send=%b want 1 0", sta, uart_send);
    end
    @(negedge clk);
    n_run++;
    if (uart_send !== 1'b1 || uart_send_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL lat_sync: got send=%b data=%h want 1 a5",
               uart_send, uart_send_data);
    end
    wait_sta(4'd3, 200, ok);
    n_run++;
    if (!ok || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done: got ok=%b busy=%b want 1 1", ok, busy);
    end
    @(negedge clk);
    exp_fc = 1;
    n_run++;
    if (busy !== 1'b0 || sta !== 4'd0 || frame_cnt !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL frame_end: got busy=%b sta=%h fc=%0d want 0 0 %0d",
               busy, sta, frame_cnt, exp_fc);
    end
    n_run++;
    if (cap_q.size() !== FLEN) begin
      n_fail++;
      $display("FAIL frame_len: got %0d want %0d", cap_q.size(), FLEN);
    end
    for (int i = 0; i < FLEN; i++) begin
      n_run++;
      if (i >= cap_q.size() || cap_q[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL frame_byte%0d: got %h want %h", i,
                 (i < cap_q.size()) ? cap_q[i] : 8'hxx, ex[i]);
      end
    end
    repeat (20) @(negedge clk);
    n_run++;
    if (cap_q.size() !== FLEN) begin
      n_fail++;
      $display("FAIL frame_extra: got %0d sends want %0d", cap_q.size(), FLEN);
    end
  endtask

  task automatic test_mid_change();
    logic [7:0] e1 [5] = '{8'hA5, 8'h02, 8'h53, 8'h0A, 8'h5B};
    logic [7:0] e2 [5] = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03};
    bit ok;
    cap_q.delete();
    resp_delay = 10;
    pulse_force();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cap_q.size() >= 2) ok = 1'b1;
    end
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_second: got %0d sends want 2", cap_q.size());
    end
    key_down = 12'h001;
    wait_sta(4'd3, 200, ok);
    exp_fc = 2;
    n_run++;
    if (!ok || cap_q.size() !== FLEN) begin
      n_fail++;
      $display("FAIL mid_first_done: got ok=%b n=%0d want 1 %0d",
               ok, cap_q.size(), FLEN);
    end
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (sta !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_gap: got sta=%h want 1", sta);
    end
    wait_sta(4'd3, 200, ok);
    @(negedge clk);
    exp_fc = 3;
    n_run++;
    if (!ok || frame_cnt !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL mid_fc: got ok=%b fc=%0d want 1 %0d", ok, frame_cnt, exp_fc);
    end
    for (int i = 0; i < 2 * FLEN; i++) begin
      logic [7:0] w;
      w = (i < FLEN) ? e1[i] : e2[i - FLEN];
      n_run++;
      if (i >= cap_q.size() || cap_q[i] !== w) begin
        n_fail++;
        $display("FAIL mid_byte%0d: got %h want %h", i,
                 (i < cap_q.size()) ? cap_q[i] : 8'hxx, w);
      end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] ex [5] = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03};
    bit ok;
    int n;
    resp_delay = 0;
    wait_sta(4'd1, 150, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL per_first: got sta=%h want 1 within 150", sta);
    end
    for (int r = 0; r < 2; r++) begin
      cap_q.delete();
      wait_sta(4'd3, 50, ok);
      exp_fc++;
      @(negedge clk);
      n = 0;
      while (sta === 4'd0 && n < 200) begin
        n++;
        @(negedge clk);
      end
      n_run++;
      if (!ok || n !== 100) begin
        n_fail++;
        $display("FAIL per_gap%0d: got ok=%b idle=%0d want 1 100", r, ok, n);
      end
      n_run++;
      if (frame_cnt !== 16'(exp_fc)) begin
        n_fail++;
        $display("FAIL per_fc%0d: got %0d want %0d", r, frame_cnt, exp_fc);
      end
      for (int i = 0; i < FLEN; i++) begin
        n_run++;
        if (i >= cap_q.size() || cap_q[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL per_byte%0d_%0d: got %h want %h", r, i,
                   (i < cap_q.size()) ? cap_q[i] : 8'hxx, ex[i]);
        end
      end
    end
    wait_sta(4'd3, 50, ok);
    exp_fc++;
    repeat (30) @(negedge clk);
    pulse_force();
    n_run++;
    if (sta !== 4'd1) begin
      n_fail++;
      $display("FAIL force_start: got sta=%h want 1", sta);
    end
    wait_sta(4'd3, 50, ok);
    @(negedge clk);
    exp_fc++;
    n_run++;
    if (!ok || frame_cnt !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL force_fc: got ok=%b fc=%0d want 1 %0d", ok, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok;
    cap_q.delete();
    resp_delay = 49;
    pulse_force();
    wait_sta(4'd3, 400, ok);
    @(negedge clk);
    exp_fc++;
    n_run++;
    if (!ok || err !== 1'b0 || frame_cnt !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL edge_done: got ok=%b err=%b fc=%0d want 1 0 %0d",
               ok, err, frame_cnt, exp_fc);
    end
    n_run++;
    if (cap_q.size() !== FLEN) begin
      n_fail++;
      $display("FAIL edge_len: got %0d want %0d", cap_q.size(), FLEN);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] ex [5] = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03};
    bit ok;
    int n;
    cap_q.delete();
    resp_delay = -1;
    pulse_force();
    wait_sta(4'd2, 10, ok);
    n_run++;
    if (!ok || err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_wait: got ok=%b err=%b want 1 0", ok, err);
    end
    n = 0;
    while (sta === 4'd2 && n < 200) begin
      n++;
      @(negedge clk);
    end
    n_run++;
    if (n !== 50) begin
      n_fail++;
      $display("FAIL tmo_cycles: got %0d want 50", n);
    end
    n_run++;
    if (err !== 1'b1 || busy !== 1'b0 || sta !== 4'd0) begin
      n_fail++;
      $display("FAIL tmo_flags: got err=%b busy=%b sta=%h want 1 0 0",
               err, busy, sta);
    end
    n_run++;
    if (frame_cnt !== 16'(exp_fc) || cap_q.size() !== 1) begin
      n_fail++;
      $display("FAIL tmo_fc: got fc=%0d n=%0d want %0d 1",
               frame_cnt, cap_q.size(), exp_fc);
    end
    cap_q.delete();
    resp_delay = 10;
    pulse_force();
    wait_sta(4'd3, 200, ok);
    @(negedge clk);
    exp_fc++;
    n_run++;
    if (!ok || err !== 1'b1 || frame_cnt !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL tmo_retry: got ok=%b err=%b fc=%0d want 1 1 %0d",
               ok, err, frame_cnt, exp_fc);
    end
    for (int i = 0; i < FLEN; i++) begin
      n_run++;
      if (i >= cap_q.size() || cap_q[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL tmo_byte%0d: got %h want %h", i,
                 (i < cap_q.size()) ? cap_q[i] : 8'hxx, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ex [5] = '{8'hA5, 8'h02, 8'hC5, 8'h03, 8'hC4};
    bit ok;
    cap_q.delete();
    resp_delay = 10;
    key_down = 12'h3C5;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cap_q.size() >= 2) ok = 1'b1;
    end
    #2;
    rst = 1'b0;
    #1;
    n_run++;
    if (!ok || {uart_send, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_flags: got ok=%b flags=%b want 1 000",
               ok, {uart_send, busy, err});
    end
    n_run++;
    if (frame_cnt !== 16'd0 || sta !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_cnt: got fc=%0d sta=%h want 0 0", frame_cnt, sta);
    end
    @(negedge clk);
    @(negedge clk);
    cap_q.delete();
    rst = 1'b1;
    wait_sta(4'd3, 200, ok);
    @(negedge clk);
    n_run++;
    if (!ok || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rstmid_fc: got ok=%b fc=%0d want 1 1", ok, frame_cnt);
    end
    for (int i = 0; i < FLEN; i++) begin
      n_run++;
      if (i >= cap_q.size() || cap_q[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL rstmid_byte%0d: got %h want %h", i,
                 (i < cap_q.size()) ? cap_q[i] : 8'hxx, ex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_mid_change();
    test_periodic();
    test_done_at_timeout();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
